// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU op encoding, ctrl bit indices,
// the canonical NOP word and the ID/EX pipeline register layout.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // ALU op is {funct7[5], funct3}; only the named points are listed.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  localparam int CTRL_REG_WRITE   = 0;
  localparam int CTRL_MEM_READ    = 1;
  localparam int CTRL_MEM_WRITE   = 2;
  localparam int CTRL_BRANCH      = 3;
  localparam int CTRL_JUMP        = 4;
  localparam int CTRL_JALR        = 5;
  localparam int CTRL_ALU_SRC_IMM = 6;
  localparam int CTRL_ILLEGAL     = 7;

  // An all-zero value of this struct is a pipeline bubble.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic [7:0]  ctrl;
  } id_ex_t;

endpackage

// File: rtl/id_stage_imm_gen.sv
// Immediate generator: picks the I/S/B/U/J format from the opcode and
// sign-extends to 32 bits; formats without an immediate produce zero.
module imm_gen
  import rv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_JALR, OPC_LOAD, OPC_OP_IMM:
        imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {instr[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, decoder, 32x32 register file, load-use
// hazard stall and ID/EX register. Define ID_WB_BYPASS_EN to forward WB writes to same-cycle reads.
module id_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = RV_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        flush,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall_if,
  output logic        id_ex_valid,
  output logic [31:0] id_ex_pc,
  output logic [31:0] id_ex_rs1_data,
  output logic [31:0] id_ex_rs2_data,
  output logic [31:0] id_ex_imm,
  output logic [4:0]  id_ex_rs1,
  output logic [4:0]  id_ex_rs2,
  output logic [4:0]  id_ex_rd,
  output logic [3:0]  id_ex_alu_op,
  output logic [7:0]  id_ex_ctrl
);

  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        stall_q;

  logic [31:0] regs [32];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [7:0]  ctrl_d;
  logic [3:0]  alu_op_d;
  logic        use_rs1, use_rs2;
  logic [4:0]  rs1_idx, rs2_idx;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] imm;
  logic        load_use;
  id_ex_t      id_ex_d, id_ex_q;

  assign opcode    = if_id_instr[6:0];
  assign rd_f      = if_id_instr[11:7];
  assign funct3    = if_id_instr[14:12];
  assign rs1_f     = if_id_instr[19:15];
  assign rs2_f     = if_id_instr[24:20];
  assign funct7_b5 = if_id_instr[30];

  always_comb begin
    ctrl_d   = '0;
    alu_op_d = ALU_ADD;
    use_rs1  = 1'b1;
    use_rs2  = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        ctrl_d[CTRL_REG_WRITE]   = 1'b1;
        ctrl_d[CTRL_ALU_SRC_IMM] = 1'b1;
        use_rs1                  = 1'b0;
      end
      OPC_JAL: begin
        ctrl_d[CTRL_REG_WRITE] = 1'b1;
        ctrl_d[CTRL_JUMP]      = 1'b1;
        use_rs1                = 1'b0;
      end
      OPC_JALR: begin
        ctrl_d[CTRL_REG_WRITE]   = 1'b1;
        ctrl_d[CTRL_JUMP]        = 1'b1;
        ctrl_d[CTRL_JALR]        = 1'b1;
        ctrl_d[CTRL_ALU_SRC_IMM] = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_d[CTRL_BRANCH] = 1'b1;
        use_rs2             = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_d[CTRL_REG_WRITE]   = 1'b1;
        ctrl_d[CTRL_MEM_READ]    = 1'b1;
        ctrl_d[CTRL_ALU_SRC_IMM] = 1'b1;
      end
      OPC_STORE: begin
        ctrl_d[CTRL_MEM_WRITE]   = 1'b1;
        ctrl_d[CTRL_ALU_SRC_IMM] = 1'b1;
        use_rs2                  = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl_d[CTRL_REG_WRITE]   = 1'b1;
        ctrl_d[CTRL_ALU_SRC_IMM] = 1'b1;
        // Only shift-immediates carry an operation bit in funct7.
        alu_op_d = (funct3 == 3'b001 || funct3 == 3'b101) ? {funct7_b5, funct3}
                                                           : {1'b0, funct3};
      end
      OPC_OP: begin
        ctrl_d[CTRL_REG_WRITE] = 1'b1;
        alu_op_d               = {funct7_b5, funct3};
        use_rs2                = 1'b1;
      end
      default: ctrl_d[CTRL_ILLEGAL] = 1'b1;
    endcase
  end

  // Unused source indices read as x0 so EX forwarding never matches them.
  assign rs1_idx = use_rs1 ? rs1_f : 5'd0;
  assign rs2_idx = use_rs2 ? rs2_f : 5'd0;

  imm_gen u_imm_gen (
    .instr (if_id_instr),
    .imm   (imm)
  );

  always_comb begin
    rs1_data = (rs1_idx == 5'd0) ? 32'd0 : regs[rs1_idx];
    rs2_data = (rs2_idx == 5'd0) ? 32'd0 : regs[rs2_idx];
`ifdef ID_WB_BYPASS_EN
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs1_idx) rs1_data = wb_data;
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs2_idx) rs2_data = wb_data;
`endif
  end

  // NOTE: register-file storage has no reset; software initialises it and
  // leaving it out keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (wb_we && wb_rd != 5'd0) regs[wb_rd] <= wb_data;
  end

  assign load_use = ex_mem_read && (ex_rd != 5'd0) && if_id_valid &&
                    ((use_rs1 && rs1_f == ex_rd) || (use_rs2 && rs2_f == ex_rd));

  // stall_q suppresses a second stall for the same load once the bubble is issued.
  assign stall_if = load_use && !flush && !stall_q;

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= 1'b0;
    else     stall_q <= stall_if;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (flush) begin
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (!stall_if) begin
      if_id_pc    <= if_pc;
      if_id_instr <= if_instr;
      if_id_valid <= 1'b1;
    end
  end

  always_comb begin
    id_ex_d = '0;
    if (if_id_valid && !flush && !stall_if) begin
      id_ex_d.valid    = 1'b1;
      id_ex_d.pc       = if_id_pc;
      id_ex_d.rs1_data = rs1_data;
      id_ex_d.rs2_data = rs2_data;
      id_ex_d.imm      = ctrl_d[CTRL_ILLEGAL] ? 32'd0 : imm;
      id_ex_d.rs1      = rs1_idx;
      id_ex_d.rs2      = rs2_idx;
      id_ex_d.rd       = ctrl_d[CTRL_REG_WRITE] ? rd_f : 5'd0;
      id_ex_d.alu_op   = alu_op_d;
      id_ex_d.ctrl     = ctrl_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) id_ex_q <= '0;
    else     id_ex_q <= id_ex_d;
  end

  assign id_ex_valid    = id_ex_q.valid;
  assign id_ex_pc       = id_ex_q.pc;
  assign id_ex_rs1_data = id_ex_q.rs1_data;
  assign id_ex_rs2_data = id_ex_q.rs2_data;
  assign id_ex_imm      = id_ex_q.imm;
  assign id_ex_rs1      = id_ex_q.rs1;
  assign id_ex_rs2      = id_ex_q.rs2;
  assign id_ex_rd       = id_ex_q.rd;
  assign id_ex_alu_op   = id_ex_q.alu_op;
  assign id_ex_ctrl     = id_ex_q.ctrl;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic
// compared against an instruction-level reference model of the decode stage.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc, if_instr;
  logic        flush, ex_mem_read, wb_we;
  logic [4:0]  ex_rd, wb_rd;
  logic [31:0] wb_data;
  logic        stall_if, id_ex_valid;
  logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [3:0]  id_ex_alu_op;
  logic [7:0]  id_ex_ctrl;

  int n_cmp = 0;
  int n_err = 0;

  id_stage dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr), .flush(flush),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .stall_if(stall_if), .id_ex_valid(id_ex_valid),
    .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
    .id_ex_imm(id_ex_imm), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_alu_op(id_ex_alu_op), .id_ex_ctrl(id_ex_ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_op;
    logic [7:0]  ctrl;
  } exp_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Reference model state: IF/ID contents, register file, expected ID/EX.
  logic [31:0] m_pc, m_instr;
  logic        m_valid, m_stalled, m_stall;
  logic [31:0] m_regs [32];
  exp_t        m_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e;
    e.valid = 1'b0; e.pc = 0; e.rs1_data = 0; e.rs2_data = 0; e.imm = 0;
    e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.alu_op = 0; e.ctrl = 0;
    return e;
  endfunction

  function automatic void m_uses(input logic [31:0] ins, output logic u1, output logic u2);
    u1 = !(ins[6:0] inside {7'h37, 7'h17, 7'h6f});
    u2 = ins[6:0] inside {7'h63, 7'h23, 7'h33};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
    if (wb_we && wb_rd == a) return wb_data;
`endif
    return m_regs[a];
  endfunction

  function automatic exp_t m_decode(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    logic signed [11:0] i12, s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic [2:0] f3;
    logic u1, u2;
    e = bubble();
    e.valid = 1'b1;
    e.pc    = pc;
    f3  = ins[14:12];
    i12 = ins[31:20];
    s12 = {ins[31:25], ins[11:7]};
    b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    case (ins[6:0])
      7'h37, 7'h17: begin e.ctrl = 8'h41; e.imm = ins & 32'hFFFF_F000; end
      7'h6f: begin e.ctrl = 8'h11; e.imm = int'(j21); end
      7'h67: begin e.ctrl = 8'h71; e.imm = int'(i12); end
      7'h63: begin e.ctrl = 8'h08; e.imm = int'(b13); end
      7'h03: begin e.ctrl = 8'h43; e.imm = int'(i12); end
      7'h23: begin e.ctrl = 8'h44; e.imm = int'(s12); end
      7'h13: begin
        e.ctrl = 8'h41; e.imm = int'(i12);
        e.alu_op = (f3 == 3'd1 || f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3};
      end
      7'h33: begin e.ctrl = 8'h01; e.alu_op = {ins[30], f3}; end
      default: e.ctrl = 8'h80;
    endcase
    m_uses(ins, u1, u2);
    e.rs1      = u1 ? ins[19:15] : 5'd0;
    e.rs2      = u2 ? ins[24:20] : 5'd0;
    e.rs1_data = m_read(e.rs1);
    e.rs2_data = m_read(e.rs2);
    e.rd       = e.ctrl[0] ? ins[11:7] : 5'd0;
    return e;
  endfunction

  task automatic check_outputs();
    check("valid",    {31'd0, id_ex_valid}, {31'd0, m_exp.valid});
    check("pc",       id_ex_pc,       m_exp.pc);
    check("rs1_data", id_ex_rs1_data, m_exp.rs1_data);
    check("rs2_data", id_ex_rs2_data, m_exp.rs2_data);
    check("imm",      id_ex_imm,      m_exp.imm);
    check("rs1",      {27'd0, id_ex_rs1}, {27'd0, m_exp.rs1});
    check("rs2",      {27'd0, id_ex_rs2}, {27'd0, m_exp.rs2});
    check("rd",       {27'd0, id_ex_rd},  {27'd0, m_exp.rd});
    check("alu_op",   {28'd0, id_ex_alu_op}, {28'd0, m_exp.alu_op});
    check("ctrl",     {24'd0, id_ex_ctrl},   {24'd0, m_exp.ctrl});
  endtask

  // One clock: check the combinational stall, advance the model at the edge,
  // then check the registered outputs on the falling edge.
  task automatic step();
    logic u1, u2, hz;
    #1;
    if (rst) begin
      m_stall = 1'b0;
    end else begin
      m_uses(m_instr, u1, u2);
      hz = m_valid && ex_mem_read && ex_rd != 0 &&
           ((u1 && m_instr[19:15] == ex_rd) || (u2 && m_instr[24:20] == ex_rd));
      m_stall = hz && !flush && !m_stalled;
    end
    check("stall_if", {31'd0, stall_if}, {31'd0, m_stall});
    @(posedge clk);
    if (rst) begin
      m_pc = 0; m_instr = NOP; m_valid = 1'b0; m_stalled = 1'b0; m_exp = bubble();
    end else begin
      m_exp = (flush || m_stall || !m_valid) ? bubble() : m_decode(m_pc, m_instr);
      if (flush) begin
        m_pc = 0; m_instr = NOP; m_valid = 1'b0;
      end else if (!m_stall) begin
        m_pc = if_pc; m_instr = if_instr; m_valid = 1'b1;
      end
      m_stalled = m_stall;
      if (wb_we && wb_rd != 0) m_regs[wb_rd] = wb_data;
    end
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r[6:0] = 7'h37;  1: r[6:0] = 7'h17;  2: r[6:0] = 7'h6f;
      3: r[6:0] = 7'h67;  4: r[6:0] = 7'h63;  5: r[6:0] = 7'h03;
      6: r[6:0] = 7'h23;  7: r[6:0] = 7'h13;  8: r[6:0] = 7'h33;
      default: r[6:0] = ($urandom_range(0, 1) == 0) ? 7'h0b : 7'h7f;
    endcase
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  localparam logic [31:0] ADD_X3_X2_X1 = 32'h0011_01B3;
  localparam logic [31:0] LUI_X2       = 32'h0001_1137;  // rs1 field holds 2, unused
  localparam logic [31:0] ADDI_X6_X5   = 32'h0002_8313;
  localparam logic [31:0] ADD_X7_X0_X0 = 32'h0000_03B3;
  localparam logic [31:0] BEQ_M4       = 32'hFE00_0EE3;

  initial begin
    rst = 1'b1; if_pc = 0; if_instr = NOP; flush = 0; ex_mem_read = 0; ex_rd = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
    @(negedge clk);
    step();  // reset state: bubble outputs, no stall

    // Load every register with a known random value under flush.
    rst = 0; flush = 1; wb_we = 1;
    for (int i = 0; i < 32; i++) begin
      wb_rd = 5'(i); wb_data = $urandom;
      step();
    end
    flush = 0; wb_we = 0;

    // First instruction after reset reaches ID/EX two edges later.
    rst = 1; if_pc = 0; if_instr = 32'h0050_0093;
    step();
    rst = 0;
    step();
    if_pc = 4; if_instr = NOP;
    step();
    check("addi_imm",   id_ex_imm, 32'd5);
    check("addi_rd",    {27'd0, id_ex_rd}, 32'd1);
    check("addi_ctrl",  {24'd0, id_ex_ctrl}, 32'h41);
    check("addi_valid", {31'd0, id_ex_valid}, 32'd1);

    // Load-use hazard: one stall, one bubble, then the add issues even if EX still shows the load.
    if_pc = 8; if_instr = ADD_X3_X2_X1;
    step();
    ex_mem_read = 1; ex_rd = 2; if_pc = 12; if_instr = NOP;
    #1 check("ldu_stall", {31'd0, stall_if}, 32'd1);
    step();
    check("ldu_bubble", {31'd0, id_ex_valid}, 32'd0);
    #1 check("ldu_one_cycle", {31'd0, stall_if}, 32'd0);
    step();
    check("ldu_issue_valid", {31'd0, id_ex_valid}, 32'd1);
    check("ldu_issue_rd",    {27'd0, id_ex_rd}, 32'd3);
    ex_mem_read = 0;

    // No stall for ex_rd=0 nor for an instruction that ignores rs1.
    if_pc = 16; if_instr = ADD_X3_X2_X1;
    step();
    ex_mem_read = 1; ex_rd = 0; if_pc = 20; if_instr = LUI_X2;
    #1 check("x0_no_stall", {31'd0, stall_if}, 32'd0);
    step();
    ex_rd = 2; if_pc = 24; if_instr = NOP;
    #1 check("lui_no_stall", {31'd0, stall_if}, 32'd0);
    step();
    ex_mem_read = 0;

    // Flush overrides a hazard.
    if_pc = 28; if_instr = ADD_X3_X2_X1;
    step();
    ex_mem_read = 1; ex_rd = 2; flush = 1;
    #1 check("flush_no_stall", {31'd0, stall_if}, 32'd0);
    step();
    check("flush_bubble", {31'd0, id_ex_valid}, 32'd0);
    flush = 0; ex_mem_read = 0;
    step();
    check("flush_ifid_invalid", {31'd0, id_ex_valid}, 32'd0);

    // Same-cycle WB write versus ID read of x5, then writes to x0.
    wb_we = 1; wb_rd = 5; wb_data = 32'h1234_5678; if_pc = 32; if_instr = ADDI_X6_X5;
    step();
    wb_data = 32'hDEAD_BEEF; if_instr = NOP;
    step();
`ifdef ID_WB_BYPASS_EN
    check("wb_bypass", id_ex_rs1_data, 32'hDEAD_BEEF);
`else
    check("wb_no_bypass", id_ex_rs1_data, 32'h1234_5678);
`endif
    wb_rd = 0; wb_data = 32'hFFFF_FFFF; if_instr = ADD_X7_X0_X0;
    step();
    step();
    check("x0_rs1", id_ex_rs1_data, 32'd0);
    check("x0_rs2", id_ex_rs2_data, 32'd0);
    wb_we = 0;

    // Illegal opcode and a negative branch offset.
    if_pc = 36; if_instr = 32'hFFFF_FFFF;
    step();
    if_pc = 40; if_instr = BEQ_M4;
    step();
    check("illegal_ctrl", {24'd0, id_ex_ctrl}, 32'h80);
    if_instr = NOP;
    step();
    check("beq_imm",  id_ex_imm, 32'hFFFF_FFFC);
    check("beq_ctrl", {24'd0, id_ex_ctrl}, 32'h08);

    // Reset in the middle of a stall drops stall_if at once.
    if_pc = 44; if_instr = ADD_X3_X2_X1;
    step();
    ex_mem_read = 1; ex_rd = 2;
    #1 check("pre_rst_stall", {31'd0, stall_if}, 32'd1);
    rst = 1;
    #1 check("rst_clears_stall", {31'd0, stall_if}, 32'd0);
    step();
    rst = 0; ex_mem_read = 0;
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_rd       = 5'($urandom_range(0, 7));
      wb_we       = $urandom_range(0, 1) == 1;
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      if_pc       = $urandom & 32'hFFFF_FFFC;
      if_instr    = gen_instr();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter NOP_INSTR, 32'h0000_0013, instruction word loaded on reset/flush/bubble.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset rst, asynchronous, active-high.
REQ-004 if_pc / if_instr  in  32/32  PC and instruction word from fetch.
REQ-005 flush  in  1  taken branch/jump resolved in EX.
REQ-006 ex_mem_read / ex_rd  in  1/5  load currently in EX and its destination.
REQ-007 wb_we / wb_rd / wb_data  in  1/5/32  register-file write port from WB.
REQ-008 stall_if  out  1  fetch shall hold PC and instruction this cycle.
REQ-009 id_ex_valid  out  1  ID/EX holds a real instruction.
REQ-010 id_ex_pc / id_ex_rs1_data / id_ex_rs2_data / id_ex_imm  out  32 each.
REQ-011 id_ex_rs1 / id_ex_rs2 / id_ex_rd  out  5 each  register indices for forwarding.
REQ-012 id_ex_alu_op  out  4  {funct7[5], funct3} for R-type/shift-imm; {0, funct3} other OP-IMM; 4'b0000 (ADD) otherwise.
REQ-013 id_ex_ctrl  out  8  [0]reg_write [1]mem_read [2]mem_write [3]branch [4]jump [5]jalr [6]alu_src_imm [7]illegal.

Function
REQ-014 Internal IF/ID register (pc, instr, valid) shall capture if_pc/if_instr each edge unless held or flushed.
REQ-015 Decode, immediate generation and register read shall be combinational from IF/ID; ID/EX register captures result next edge (1-cycle ID latency).
REQ-016 Immediates: I, S, B, U, J formats, sign-extended to 32 bits; B/J bit 0 zero.
REQ-017 Opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP decoded; any other opcode sets ctrl[7], clears ctrl[6:0].
REQ-018 rs1 used by all except LUI, AUIPC, JAL; rs2 used only by BRANCH, STORE, OP.
REQ-019 Load-use hazard: ex_mem_read=1, ex_rd!=0, ex_rd equals a used rs1/rs2 of a valid IF/ID entry -> stall_if=1, IF/ID held, ID/EX loads bubble.
REQ-020 Bubble: id_ex_valid=0, ctrl=0, all data fields 0.
REQ-021 flush=1: IF/ID loads NOP_INSTR with valid=0, ID/EX loads bubble, stall_if=0; flush overrides hazard.
REQ-022 Register file 32x32; x0 reads 0, writes to x0 ignored; written on rising edge when wb_we=1.
REQ-023 stall_if shall be combinational, asserted only in the hazard cycle; a stall lasts exactly one cycle per load.
REQ-024 Decoded rd forced to 0 when ctrl[0]=0.

Reset
REQ-025 While rst=1: IF/ID = {pc 0, NOP_INSTR, valid 0}; ID/EX bubble; all outputs 0 except stall_if=0.
REQ-026 Register file contents not reset; reset mid-stall shall clear the stall immediately.
REQ-027 First instruction after rst deassert shall reach ID/EX two edges after fetch presents it.

Configuration
REQ-028 Macro ID_WB_BYPASS_EN defined: read of register equal to wb_rd (nonzero, wb_we=1) in same cycle returns wb_data.
REQ-029 Macro undefined: read returns stored (pre-write) value; EX forwarding covers the case.

Structure
REQ-030 Shared package rv_pkg: opcode constants, ALU op encoding, ctrl bit indices, NOP_INSTR value.
REQ-031 One sub-module imm_gen (instr in, imm out, combinational); register file stays inside id_stage.

Verification
REQ-032 rst, then if_instr=32'h00500093 (addi x1,x0,5), pc 0 -> after 2 edges id_ex_imm=5, rd=1, ctrl=8'h41, valid=1.
REQ-033 ex_mem_read=1, ex_rd=2, ID holds add x3,x2,x1 -> stall_if=1 one cycle, bubble in ID/EX, add issued next cycle.
REQ-034 Same hazard with ex_rd=0 or instruction lui x2 -> stall_if=0.
REQ-035 flush=1 together with hazard -> stall_if=0, id_ex_valid=0, next cycle IF/ID valid=0.
REQ-036 wb_we=1, wb_rd=5, wb_data=32'hDEAD_BEEF while ID reads x5 -> rs1_data DEADBEEF with ID_WB_BYPASS_EN, old value without; write to x0 -> x0 reads 0.
REQ-037 if_instr=32'hFFFFFFFF -> ctrl=8'h80; beq imm -4 -> id_ex_imm=32'hFFFFFFFC.
